// File: rtl/n64_poller.sv
`default_nettype none
// ============================================================================
// Module   : n64_poller
// Purpose  : Periodically polls an N64 controller over the joybus. It sends
//            command 0x01 and captures the 32-bit reply. When N64_ERR_CNT_EN
//            is defined, it adds a saturating timeout counter on err_cnt.
// Revision : 1.0
// ============================================================================
module n64_poller #(
    parameter int CYC_PER_US = 50,
    parameter int POLL_US    = 1000,
    parameter int TIMEOUT_US = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jb_in,
    output logic        jb_oe,
    output logic [31:0] cntlr_data,
    output logic        set_cntlr_data_rdy,
    output logic        timeout_err
`ifdef N64_ERR_CNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);
    localparam int c_poll_cyc = POLL_US * CYC_PER_US;
    localparam int c_to_cyc   = TIMEOUT_US * CYC_PER_US;
    localparam int c_bit_cyc  = 4 * CYC_PER_US;
    localparam int c_cnt_max  = (c_to_cyc > c_bit_cyc) ? c_to_cyc : c_bit_cyc;
    localparam int c_poll_w   = $clog2(c_poll_cyc + 1);
    localparam int c_cnt_w    = $clog2(c_cnt_max + 1);

    localparam logic [c_poll_w-1:0] c_poll_last = c_poll_w'(c_poll_cyc - 1);
    localparam logic [c_poll_w-1:0] c_poll_one  = c_poll_w'(1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]  c_one_us    = c_cnt_w'(CYC_PER_US);
    localparam logic [c_cnt_w-1:0]  c_three_us  = c_cnt_w'(3 * CYC_PER_US);
    localparam logic [c_cnt_w-1:0]  c_one_last  = c_cnt_w'(CYC_PER_US - 1);
    localparam logic [c_cnt_w-1:0]  c_samp_last = c_cnt_w'(2 * CYC_PER_US - 1);
    localparam logic [c_cnt_w-1:0]  c_bit_last  = c_cnt_w'(c_bit_cyc - 1);
    localparam logic [c_cnt_w-1:0]  c_to_last   = c_cnt_w'(c_to_cyc - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TX_BIT  = 3'd1,
        TX_STOP = 3'd2,
        RX_WAIT = 3'd3,
        RX_BIT  = 3'd4,
        RX_STOP = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_sync1, r_sync2, r_line_d;
    logic [c_poll_w-1:0]   r_poll_cnt;
    logic                  r_pending;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [5:0]            r_bit_idx;
    logic                  r_sampled;
    logic                  r_seen_fall;
    logic [31:0]           r_shift;
    logic [31:0]           r_cntlr_data;
    logic                  r_rdy;
    logic                  r_to;

    logic                  w_line;
    logic                  w_fall;
    logic                  w_poll_exp;
    logic                  w_to_hit;
    logic [c_cnt_w-1:0]    w_low_len;
    logic                  w_oe;
    logic                  w_sample;
    logic                  w_abort;

    assign w_line     = r_sync2;
    assign w_fall     = r_line_d & ~r_sync2;
    assign w_poll_exp = (r_poll_cnt == c_poll_last);
    assign w_to_hit   = (r_cnt == c_to_last);
    // Command 0x01 sent MSB first: only the eighth bit is a one.
    assign w_low_len  = (r_bit_idx[2:0] == 3'd7) ? c_one_us : c_three_us;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_line_d   <= 1'b1;
            r_poll_cnt <= '0;
            r_pending  <= 1'b0;
        end else begin
            r_sync1    <= jb_in;
            r_sync2    <= r_sync1;
            r_line_d   <= r_sync2;
            r_poll_cnt <= w_poll_exp ? '0 : r_poll_cnt + c_poll_one;
            if (w_poll_exp)
                r_pending <= 1'b1;
            else if (r_state == IDLE && w_state_nxt == TX_BIT)
                r_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_oe        = 1'b0;
        w_sample    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pending && w_line)
                    w_state_nxt = TX_BIT;
            end
            TX_BIT: begin
                w_oe = (r_cnt < w_low_len);
                if (r_cnt == c_bit_last && r_bit_idx[2:0] == 3'd7)
                    w_state_nxt = TX_STOP;
            end
            TX_STOP: begin
                w_oe = 1'b1;
                if (r_cnt == c_one_last)
                    w_state_nxt = RX_WAIT;
            end
            RX_WAIT: begin
                if (w_fall)
                    w_state_nxt = RX_BIT;
                else if (w_to_hit)
                    w_abort = 1'b1;
            end
            RX_BIT: begin
                w_sample = ~r_sampled && (r_cnt == c_samp_last);
                if (r_sampled && w_line)
                    w_state_nxt = (r_bit_idx == 6'd31) ? RX_STOP : RX_WAIT;
                else if (w_to_hit)
                    w_abort = 1'b1;
            end
            RX_STOP: begin
                if (r_seen_fall && w_line)
                    w_state_nxt = DONE;
                else if (w_to_hit)
                    w_abort = 1'b1;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (w_abort)
            w_state_nxt = IDLE;
    end

    // The wait counter restarts on every state change so each wait gets its own timeout budget.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_sampled    <= 1'b0;
            r_seen_fall  <= 1'b0;
            r_shift      <= '0;
            r_cntlr_data <= '0;
            r_rdy        <= 1'b0;
            r_to         <= 1'b0;
        end else begin
            if (r_state != w_state_nxt || r_state == IDLE || r_state == DONE)
                r_cnt <= '0;
            else if (r_state == TX_BIT && r_cnt == c_bit_last)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + c_cnt_one;

            if (r_state == IDLE || r_state == TX_STOP)
                r_bit_idx <= '0;
            else if (r_state == TX_BIT && r_cnt == c_bit_last)
                r_bit_idx <= r_bit_idx + 6'd1;
            else if (r_state == RX_BIT && w_state_nxt != RX_BIT && !w_abort)
                r_bit_idx <= r_bit_idx + 6'd1;

            r_sampled   <= (r_state == RX_BIT && w_state_nxt == RX_BIT) ? (r_sampled | w_sample) : 1'b0;
            r_seen_fall <= (r_state == RX_STOP && w_state_nxt == RX_STOP) ? (r_seen_fall | w_fall) : 1'b0;

            // Byte k of the reply lands in [8k+7:8k], received MSB first.
            if (r_state == IDLE)
                r_shift <= '0;
            else if (w_sample)
                r_shift[{r_bit_idx[4:3], ~r_bit_idx[2:0]}] <= w_line;

            if (r_state == DONE)
                r_cntlr_data <= r_shift;
            r_rdy <= (r_state == DONE);
            r_to  <= w_abort;
        end
    end

    assign jb_oe              = w_oe;
    assign cntlr_data         = r_cntlr_data;
    assign set_cntlr_data_rdy = r_rdy;
    assign timeout_err        = r_to;

`ifdef N64_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err_cnt <= 8'd0;
        else if (w_abort && r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_n64_poller.sv
`default_nettype none
// ============================================================================
// Module   : tb_n64_poller
// Purpose  : Table of poll transactions against a joybus controller model,
//            with pulse scoreboard, plus reset and mid-command reset sequences.
// Revision : 1.0
// ============================================================================
module tb_n64_poller;
    localparam int CYC      = 4;
    localparam int POLL     = 200;
    localparam int TOUT     = 16;
    localparam int POLL_CYC = POLL * CYC;

    typedef struct {
        logic [31:0] reply;
        int          nbits;
        bit          stop;
        bit          exp_ok;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        bit          is_rdy;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dev_low = 1'b0;
    logic        jb_in;
    logic        jb_oe;
    logic [31:0] cntlr_data;
    logic        set_cntlr_data_rdy;
    logic        timeout_err;
`ifdef N64_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] m_data = 32'h0;
    logic [31:0] last_good = 32'h0;
    int          n_to = 0;
    time         prev_start = 0;
    bit          have_prev = 1'b0;
    vec_t        vecs[8];

    // Open-drain bus: either side pulling low wins.
    assign jb_in = ~(jb_oe | dev_low);

    always #5 clk = ~clk;

    n64_poller #(
        .CYC_PER_US (CYC),
        .POLL_US    (POLL),
        .TIMEOUT_US (TOUT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .jb_in              (jb_in),
        .jb_oe              (jb_oe),
        .cntlr_data         (cntlr_data),
        .set_cntlr_data_rdy (set_cntlr_data_rdy),
        .timeout_err        (timeout_err)
`ifdef N64_ERR_CNT_EN
        ,
        .err_cnt            (err_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            m_data = 32'h0;
        end else begin
            chk("pulse_excl", {31'd0, set_cntlr_data_rdy & timeout_err}, 32'd0);
            if (set_cntlr_data_rdy || timeout_err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, set_cntlr_data_rdy, timeout_err}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("pulse_kind", {31'd0, set_cntlr_data_rdy}, {31'd0, mon_e.is_rdy});
                    chk("data_at_pulse", cntlr_data, mon_e.data);
                    if (mon_e.is_rdy)
                        m_data = mon_e.data;
                end
            end else begin
                chk("data_stable", cntlr_data, m_data);
            end
        end
    end

    task automatic wait_start(output int n);
        n = 0;
        while (jb_oe !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (jb_oe === lvl && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Checks one full command waveform; returns at the first released cycle after the stop bit.
    task automatic check_cmd();
        int lo, hi, elo;
        for (int i = 0; i < 8; i++) begin
            elo = (i == 7) ? CYC : 3 * CYC;
            run_len(1'b1, lo);
            chk($sformatf("cmd_low_b%0d", i), lo, elo);
            run_len(1'b0, hi);
            chk($sformatf("cmd_high_b%0d", i), hi, 4 * CYC - elo);
        end
        run_len(1'b1, lo);
        chk("cmd_stop_low", lo, CYC);
    endtask

    task automatic send_reply(input logic [31:0] reply, input int nbits, input bit stop);
        logic b;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            b = reply[31 - i];
            dev_low = 1'b1;
            repeat (b ? CYC : 3 * CYC) @(negedge clk);
            dev_low = 1'b0;
            repeat (b ? 3 * CYC : CYC) @(negedge clk);
        end
        if (stop) begin
            dev_low = 1'b1;
            repeat (CYC) @(negedge clk);
            dev_low = 1'b0;
        end
    endtask

    task automatic do_txn(input vec_t v, input int idx);
        int  n;
        exp_t e;
        wait_start(n);
        chk($sformatf("cmd_start_v%0d", idx), {31'd0, jb_oe}, 32'd1);
        if (jb_oe !== 1'b1)
            return;
        if (have_prev)
            chk($sformatf("poll_period_v%0d", idx), 32'($time - prev_start), 32'(POLL_CYC * 10));
        prev_start = $time;
        have_prev  = 1'b1;
        e.is_rdy = v.exp_ok;
        e.data   = v.exp_ok ? v.exp_data : last_good;
        sb.push_back(e);
        if (v.exp_ok)
            last_good = v.exp_data;
        else
            n_to++;
        check_cmd();
        if (v.nbits == 0) begin
            n = 0;
            while (timeout_err !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("noreply_to_latency", n, TOUT * CYC);
        end else begin
            send_reply(v.reply, v.nbits, v.stop);
        end
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("sb_drain_v%0d", idx), sb.size(), 32'd0);
        sb.delete();
`ifdef N64_ERR_CNT_EN
        chk($sformatf("err_cnt_v%0d", idx), {24'd0, err_cnt}, n_to);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{32'h800012F4, 32, 1'b1, 1'b1, 32'hF4120080};
        vecs[1] = '{32'h00000000,  0, 1'b0, 1'b0, 32'h00000000};
        vecs[2] = '{32'h1234ABCD, 16, 1'b0, 1'b0, 32'h00000000};
        vecs[3] = '{32'hFFFFFFFF, 32, 1'b1, 1'b1, 32'hFFFFFFFF};
        vecs[4] = '{32'h00000000, 32, 1'b1, 1'b1, 32'h00000000};
        vecs[5] = '{32'hA55A0FF0, 32, 1'b1, 1'b1, 32'hF00F5AA5};
        vecs[6] = '{32'h01020304, 32, 1'b0, 1'b0, 32'h00000000};
        vecs[7] = '{32'h01020304, 32, 1'b1, 1'b1, 32'h04030201};

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("rst_oe", {31'd0, jb_oe}, 32'd0);
            chk("rst_data", cntlr_data, 32'd0);
            chk("rst_pulses", {30'd0, set_cntlr_data_rdy, timeout_err}, 32'd0);
        end
        rst = 1'b0;
        wait_start(n);
        chk("first_poll_latency", n, POLL_CYC + 1);

        for (int i = 0; i < 8; i++)
            do_txn(vecs[i], i);

        // Reset during a low phase of the first command bit.
        wait_start(n);
        repeat (3) @(negedge clk);
        chk("midtx_pre_oe", {31'd0, jb_oe}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midtx_oe", {31'd0, jb_oe}, 32'd0);
        chk("midtx_data", cntlr_data, 32'd0);
        repeat (3) @(negedge clk);
        rst       = 1'b0;
        have_prev = 1'b0;
        last_good = 32'h0;
        n_to      = 0;
        wait_start(n);
        chk("post_rst_poll_latency", n, POLL_CYC + 1);
        do_txn(vecs[0], 8);
        do_txn(vecs[2], 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/n64_poller.md
N64_POLLER -- requirements
Module: n64_poller

Interface
REQ-001 SHALL have parameter CYC_PER_US, default 50, meaning clk cycles per microsecond.
REQ-002 SHALL have parameter POLL_US, default 1000, meaning poll period in microseconds.
REQ-003 SHALL have parameter TIMEOUT_US, default 64, meaning maximum wait for any controller edge.
REQ-004 SHALL have port clk, input, 1 bit: the only clock.
REQ-005 SHALL have port rst, input, 1 bit: reset; one clock, reset is asynchronous and active-high.
REQ-006 SHALL have port jb_in, input, 1 bit: raw joybus line level (asynchronous).
REQ-007 SHALL have port jb_oe, output, 1 bit: 1 = drive line low, 0 = release (open-drain).
REQ-008 SHALL have port cntlr_data, output, 32 bits: last valid controller response.
REQ-009 SHALL have port set_cntlr_data_rdy, output, 1 bit: one-cycle pulse when cntlr_data updates.
REQ-010 SHALL have port timeout_err, output, 1 bit: one-cycle pulse on failed transaction.

Function
REQ-011 SHALL synchronize jb_in through 2 flops (reset value 1); all line decisions use the synchronized value.
REQ-012 SHALL run a free poll timer of POLL_US*CYC_PER_US cycles; expiry sets a single pending flag (further expiries while pending are dropped).
REQ-013 SHALL use states IDLE, TX_BIT, TX_STOP, RX_WAIT, RX_BIT, RX_STOP, DONE.
REQ-014 SHALL leave IDLE for TX_BIT only when pending=1 and the synchronized line is high; it then clears pending.
REQ-015 SHALL send command 0x01 MSB first: bit 0 = 3*CYC_PER_US low + 1*CYC_PER_US released; bit 1 = 1*CYC_PER_US low + 3*CYC_PER_US released.
REQ-016 SHALL in TX_STOP drive low for 1*CYC_PER_US, then release and enter RX_WAIT.
REQ-017 SHALL in RX_WAIT wait for a falling edge; on detection enter RX_BIT and start a sample counter.
REQ-018 SHALL in RX_BIT sample the line 2*CYC_PER_US cycles after the falling edge; sampled level is the bit value.
REQ-019 SHALL after sampling wait for line high, then return to RX_WAIT, or to RX_STOP after the 32nd bit.
REQ-020 SHALL place response bytes as received byte k -> bits [8k+7:8k], each byte MSB first, so the first byte lands in [7:0].
REQ-021 SHALL in RX_STOP wait for the controller stop bit (fall, then rise), then enter DONE.
REQ-022 SHALL in DONE load cntlr_data from the shift register, pulse set_cntlr_data_rdy for exactly one cycle, and return to IDLE.
REQ-023 SHALL abort to IDLE, pulse timeout_err, and leave cntlr_data unchanged if any RX_WAIT, RX_BIT, or RX_STOP wait exceeds TIMEOUT_US*CYC_PER_US cycles.
REQ-024 SHALL hold jb_oe at 0 in every state except the low phases of TX_BIT and TX_STOP.
REQ-025 SHALL keep cntlr_data stable between set_cntlr_data_rdy pulses.
REQ-026 SHALL, on poll expiry during an active transaction, set pending and start the next transaction upon return to IDLE.
REQ-027 SHALL never assert set_cntlr_data_rdy and timeout_err in the same cycle.

Reset
REQ-028 SHALL on rst force state IDLE, jb_oe=0, cntlr_data=0, set_cntlr_data_rdy=0, timeout_err=0, pending=0, all counters 0, sync flops=1, immediately and asynchronously.
REQ-029 SHALL on rst asserted mid-transaction release the line the same cycle and discard partial data.
REQ-030 SHALL begin the first poll POLL_US after rst deasserts.

Configuration
REQ-031 SHALL, with N64_ERR_CNT_EN defined, add output err_cnt (8 bits, reset 0) that increments on each timeout_err pulse and saturates at 0xFF.
REQ-032 SHALL, without N64_ERR_CNT_EN, omit err_cnt and its logic entirely; all other behaviour is identical.

Verification (CYC_PER_US=4, POLL_US=200, TIMEOUT_US=16)
REQ-033 Reset: rst high with line pulled high -> jb_oe=0, cntlr_data=0x00000000, no pulses, for the full reset duration.
REQ-034 Command: first poll -> seven bits of 12 cycles low + 4 released, one bit of 4 low + 12 released, then 4 low for the stop bit, then released.
REQ-035 Response: model replies 0x80,0x00,0x12,0xF4 plus stop bit -> cntlr_data=0xF4120080 and one set_cntlr_data_rdy pulse.
REQ-036 No reply: line stays high -> timeout_err pulses 64 cycles after TX_STOP release, cntlr_data unchanged, next poll at the next timer expiry.
REQ-037 Truncated reply: model stops after 16 bits -> one timeout_err pulse, no rdy pulse; with N64_ERR_CNT_EN, err_cnt=1.
REQ-038 Mid-TX reset: rst asserted during a low phase of TX_BIT -> jb_oe=0 that cycle; after release, a full command is sent at the first expiry.
